bw_burst_responder: RTL and testbench

Wishbone-style bus responder at the far end of the BlackWidow core's bus interface unit. It serves classic and incrementing-burst read and write cycles against an on-chip 128-bit-wide memory. It returns `ack_o` and `bok_o` to the master. It sits on the system bus as the boot/scratch memory target that the core's fetch and load/store paths talk to.

---
 rtl/bw_burst_responder_pkg.sv | 35 +++
 rtl/bw_burst_responder_ram.sv | 35 +++
 rtl/bw_burst_responder.sv | 163 ++++++++++++++++
 tb/tb_bw_burst_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_burst_responder_pkg.sv
// Shared types for the BlackWidow bus responder: cycle/burst type encodings,
// responder FSM states and the wrap-mask helper for burst address advance.
package rfBlackWidowPkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLASSIC = 2'b01,
    ST_BURST   = 2'b10,
    ST_DONE    = 2'b11
  } resp_state_e;

  // Low beat-counter bits that roll over for a wrapping burst; linear uses none.
  function automatic logic [3:0] bte_wrap_mask(input logic [1:0] bte);
    case (bte)
      BTE_WRAP4:  bte_wrap_mask = 4'h3;
      BTE_WRAP8:  bte_wrap_mask = 4'h7;
      BTE_WRAP16: bte_wrap_mask = 4'hF;
      default:    bte_wrap_mask = 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/bw_burst_responder_ram.sv
// Single-port 2^DEPTH_LG2 x 128 RAM with byte-lane write enables,
// write-first behaviour and a registered read port.
module bw_resp_ram #(
  parameter int DEPTH_LG2 = 10
) (
  input  logic                 clk_i,
  input  logic [DEPTH_LG2-1:0] addr_i,
  input  logic                 we_i,
  input  logic [15:0]          be_i,
  input  logic [127:0]         wdata_i,
  output logic [127:0]         rdata_o
);

  logic [127:0] mem_q [0:(1<<DEPTH_LG2)-1];
  logic [127:0] rdata_q;
  logic [127:0] merged;

  // Read data already reflects the lanes written on the same edge.
  always_comb begin
    merged = mem_q[addr_i];
    for (int k = 0; k < 16; k++) begin
      if (we_i && be_i[k]) merged[k*8 +: 8] = wdata_i[k*8 +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 16; k++) begin
      if (we_i && be_i[k]) mem_q[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
    end
    rdata_q <= merged;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bw_burst_responder.sv
// Wishbone classic/incrementing-burst responder over a 128-bit on-chip RAM.
// Define BW_RESP_ERR_EN to add err_o for window misses and linear overruns.
module bw_burst_responder
  import rfBlackWidowPkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH_LG2 = 10,
  parameter logic [ADDR_W-1:0] BASE      = 32'hFFFC0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic              vpa_i,
  input  logic              vda_i,
  input  logic [2:0]        cti_i,
  input  logic [1:0]        bte_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [15:0]       sel_i,
  input  logic [127:0]      dat_i,
  output logic              ack_o,
  output logic              bok_o,
  output logic [127:0]      dat_o,
`ifdef BW_RESP_ERR_EN
  output logic              err_o,
`endif
  output resp_state_e       state_o
);

  localparam int LW = DEPTH_LG2;

  resp_state_e    state_q, state_d;
  logic [LW-1:0]  bc_q, bc_d;
  logic [LW-1:0]  bc_inc, bc_adv, adr_line;
  logic [3:0]     wrap;
  logic           hit, req, sel, beat;
  logic           ack_c, bok_c;
  logic [LW-1:0]  ram_addr;
  logic           ram_we;
  logic [127:0]   ram_rdata;
  logic           unused_adr_lo;

  assign hit      = (adr_i[ADDR_W-1:LW+4] == BASE[ADDR_W-1:LW+4]);
  assign req      = cyc_i & stb_i & (vpa_i | vda_i);
  assign sel      = req & hit;
  assign adr_line = adr_i[LW+3:4];
  assign beat     = (state_q == ST_BURST) & cyc_i & stb_i;
  assign unused_adr_lo = ^adr_i[3:0];

  // Wrapping bursts roll only the low counter bits; linear rolls at DEPTH.
  always_comb begin
    wrap   = bte_wrap_mask(bte_i);
    bc_inc = bc_q + LW'(1);
    if (bte_i == BTE_LINEAR) bc_adv = bc_inc;
    else bc_adv = {bc_q[LW-1:4], (bc_q[3:0] & ~wrap) | (bc_inc[3:0] & wrap)};
  end

`ifdef BW_RESP_ERR_EN
  logic err_q, err_d, err_c, oob;
  assign oob = (bte_i == BTE_LINEAR) & (&bc_q);
`endif

  always_comb begin
    state_d  = state_q;
    bc_d     = bc_q;
    ack_c    = 1'b0;
    bok_c    = 1'b0;
    ram_addr = bc_q;
    ram_we   = 1'b0;
`ifdef BW_RESP_ERR_EN
    err_d    = err_q;
    err_c    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        ram_addr = adr_line;
`ifdef BW_RESP_ERR_EN
        err_d = 1'b0;
        if (req & ~hit) begin
          err_d   = 1'b1;
          state_d = ST_CLASSIC;
        end
`endif
        if (sel) begin
          bc_d    = adr_line;
          ram_we  = we_i;
          state_d = (cti_i == CTI_INCR) ? ST_BURST : ST_CLASSIC;
        end
      end
      ST_CLASSIC: begin
`ifdef BW_RESP_ERR_EN
        ack_c = cyc_i & ~err_q;
        err_c = cyc_i & err_q;
`else
        ack_c = cyc_i;
`endif
        state_d = ST_DONE;
      end
      ST_BURST: begin
        // A stalled beat leaves ram_addr at bc so read data is re-fetched.
        if (beat) begin
`ifdef BW_RESP_ERR_EN
          if (oob) begin
            err_c   = 1'b1;
            state_d = ST_DONE;
          end else begin
`else
          begin
`endif
            ack_c = 1'b1;
            bok_c = 1'b1;
            bc_d  = bc_adv;
            if (we_i) begin
              ram_we   = 1'b1;
              ram_addr = bc_q;
            end else begin
              ram_addr = bc_adv;
            end
            if (cti_i == CTI_EOB) state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!cyc_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      bc_q    <= '0;
`ifdef BW_RESP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
`ifdef BW_RESP_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  bw_resp_ram #(.DEPTH_LG2(DEPTH_LG2)) u_ram (
    .clk_i   (clk_i),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (sel_i),
    .wdata_i (dat_i),
    .rdata_o (ram_rdata)
  );

  assign ack_o   = ack_c;
  assign bok_o   = bok_c;
  assign dat_o   = ack_c ? ram_rdata : '0;
  assign state_o = state_q;
`ifdef BW_RESP_ERR_EN
  assign err_o   = err_c;
`endif

endmodule

// File: tb/tb_bw_burst_responder.sv
// Directed and randomized bench for bw_burst_responder against a line-array
// reference model; burst beat addresses are derived arithmetically.
module tb_bw_burst_responder;
  import rfBlackWidowPkg::*;

  localparam int          DEPTH_LG2 = 10;
  localparam int          NLINES    = 1 << DEPTH_LG2;
  localparam logic [31:0] BASE      = 32'hFFFC0000;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic cyc_i, stb_i, we_i, vpa_i, vda_i;
  logic [2:0]   cti_i;
  logic [1:0]   bte_i;
  logic [31:0]  adr_i;
  logic [15:0]  sel_i;
  logic [127:0] dat_i;
  logic         ack_o, bok_o;
  logic [127:0] dat_o;
  resp_state_e  state_o;
`ifdef BW_RESP_ERR_EN
  logic         err_o;
`endif

  int total = 0;
  int bad   = 0;
  logic [127:0] model_mem [NLINES];
  logic [127:0] exp_q [$];

  bw_burst_responder #(.ADDR_W(32), .DEPTH_LG2(DEPTH_LG2), .BASE(BASE)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .vpa_i(vpa_i), .vda_i(vda_i), .cti_i(cti_i), .bte_i(bte_i), .adr_i(adr_i),
    .sel_i(sel_i), .dat_i(dat_i), .ack_o(ack_o), .bok_o(bok_o), .dat_o(dat_o),
`ifdef BW_RESP_ERR_EN
    .err_o(err_o),
`endif
    .state_o(state_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] line_adr(input int line);
    return BASE + 32'(line * 16);
  endfunction

  // Line served by beat i: wrap-n bursts stay inside the aligned n-line block.
  function automatic int beat_line(input int start, input int bte, input int i);
    int n;
    n = (bte == 0) ? NLINES : (4 << (bte - 1));
    return (start - start % n) + ((start % n) + i) % n;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_write(input int line, input logic [15:0] sel, input logic [127:0] d);
    for (int k = 0; k < 16; k++) if (sel[k]) model_mem[line][k*8 +: 8] = d[k*8 +: 8];
  endtask

  task automatic idle_bus();
    cyc_i = 0; stb_i = 0; we_i = 0; vpa_i = 0; vda_i = 0;
    cti_i = 3'b000; bte_i = 2'b00; adr_i = '0; sel_i = '0; dat_i = '0;
  endtask

  // Driver: classic single access, strobe held through the DONE cycle.
  task automatic classic(input bit wr, input int line, input logic [15:0] sel,
                         input logic [127:0] d, input string tag);
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; vda_i = 1; vpa_i = 0; we_i = wr;
    adr_i = line_adr(line); sel_i = sel; dat_i = d; cti_i = 3'b000; bte_i = 2'b00;
    if (wr) model_write(line, sel, d);
    else exp_q.push_back(model_mem[line]);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack"}, ack_o, 1);
    check({tag, "_bok"}, bok_o, 0);
    if (!wr) check({tag, "_dat"}, dat_o, exp_q.pop_front());
    @(negedge clk);
    check({tag, "_ack_done"}, ack_o, 0);
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check({tag, "_idle"}, state_o, ST_IDLE);
  endtask

  // Driver: burst of n beats; optional 2-cycle stall after beat wait_after.
  task automatic burst(input bit wr, input int start, input int bte, input int n,
                       input int wait_after, input bit eob, input string tag);
    logic [127:0] wd [$];
    int line;
    for (int i = 0; i < n; i++) wd.push_back(rnd128());
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; vda_i = 0; vpa_i = 1; we_i = wr;
    adr_i = line_adr(start); sel_i = 16'hFFFF; dat_i = wd[0];
    cti_i = 3'b010; bte_i = 2'(bte);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      stb_i = 1;
      cti_i = (eob && i == n - 1) ? 3'b111 : 3'b010;
      dat_i = wd[i];
      adr_i = line_adr($urandom_range(0, 31));
      line = beat_line(start, bte, i);
      if (!wr) exp_q.push_back(model_mem[line]);
      @(negedge clk);
      check($sformatf("%s_ack%0d", tag, i), ack_o, 1);
      check($sformatf("%s_bok%0d", tag, i), bok_o, 1);
      if (wr) model_write(line, 16'hFFFF, wd[i]);
      else check($sformatf("%s_dat%0d", tag, i), dat_o, exp_q.pop_front());
      if (i == wait_after) begin
        for (int w = 0; w < 2; w++) begin
          @(posedge clk); #1;
          stb_i = 0;
          @(negedge clk);
          check($sformatf("%s_wait%0d", tag, w), ack_o, 0);
        end
      end
    end
    if (eob) begin
      @(posedge clk); #1;
      idle_bus();
      @(negedge clk);
      check({tag, "_end_ack"}, ack_o, 0);
      check({tag, "_end_idle"}, state_o, ST_IDLE);
    end
  endtask

  initial begin
    idle_bus();
    rst_i = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack_o, 0);
    check("rst_bok", bok_o, 0);
    check("rst_dat", dat_o, 0);
    check("rst_state", state_o, ST_IDLE);
`ifdef BW_RESP_ERR_EN
    check("rst_err", err_o, 0);
`endif
    @(posedge clk); #1;
    rst_i = 1;

    // Preload lines 0..31 with a linear write burst.
    burst(1, 0, 0, 32, -1, 1, "preload");

    classic(1, 5, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF, "wr5");
    classic(0, 5, 16'h0000, '0, "rd5");

    classic(1, 2, 16'hFFFF, '0, "clr2");
    classic(1, 2, 16'h00F0, {128{1'b1}}, "lane2");
    classic(0, 2, 16'h0000, '0, "rd2");
    check("lane2_pattern", model_mem[2], 128'h0000000000000000_FFFFFFFF00000000);

    classic(1, 3, 16'h0000, rnd128(), "sel0");
    classic(0, 3, 16'h0000, '0, "rd3");

    burst(0, 6, 1, 4, -1, 1, "wrap4");

    // Stall after the first beat, then abort by dropping cyc.
    burst(0, 8, 0, 3, 0, 0, "waitab");
    @(posedge clk); #1;
    idle_bus();
    @(negedge clk);
    check("abort_ack", ack_o, 0);
    @(negedge clk);
    check("abort_idle", state_o, ST_IDLE);

    // Miss just below the window.
    @(posedge clk); #1;
    cyc_i = 1; stb_i = 1; vda_i = 1; we_i = 0; cti_i = 3'b000;
    adr_i = BASE - 32'd16; sel_i = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    check("miss_ack1", ack_o, 0);
`ifdef BW_RESP_ERR_EN
    check("miss_err1", err_o, 1);
    @(negedge clk);
    check("miss_err2", err_o, 0);
`else
    @(negedge clk);
    check("miss_state", state_o, ST_IDLE);
`endif
    check("miss_ack2", ack_o, 0);
    @(posedge clk); #1;
    idle_bus();
    @(posedge clk);

    // Reset asserted during beat 2 of a read burst.
    burst(0, 16, 0, 2, -1, 0, "rstb");
    @(posedge clk); #1;
    rst_i = 0;
    @(posedge clk); #1;
    rst_i = 1; vpa_i = 0; vda_i = 0;
    @(negedge clk);
    check("rstmid_ack", ack_o, 0);
    check("rstmid_bok", bok_o, 0);
    check("rstmid_dat", dat_o, 0);
    check("rstmid_state", state_o, ST_IDLE);
    @(posedge clk); #1;
    idle_bus();
    classic(0, 17, 16'h0000, '0, "after_rst");

`ifndef BW_RESP_ERR_EN
    // Linear burst crossing the top of the memory wraps to line 0.
    burst(1, NLINES - 2, 0, 4, -1, 1, "topwr");
    burst(0, NLINES - 2, 0, 4, -1, 1, "toprd");
`endif

    for (int it = 0; it < 16; it++) begin
      int op, bte, n, start, wa;
      op  = $urandom_range(0, 3);
      bte = $urandom_range(0, 3);
      if (bte == 0) begin
        n = $urandom_range(2, 8);
        start = $urandom_range(0, 32 - n);
      end else begin
        n = $urandom_range(2, 16);
        start = $urandom_range(0, 31);
      end
      wa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 2) : -1;
      case (op)
        0: classic(0, $urandom_range(0, 31), 16'h0000, '0, $sformatf("r%0d_crd", it));
        1: classic(1, $urandom_range(0, 31), 16'($urandom), rnd128(), $sformatf("r%0d_cwr", it));
        2: burst(0, start, bte, n, wa, 1, $sformatf("r%0d_brd", it));
        default: burst(1, start, bte, n, wa, 1, $sformatf("r%0d_bwr", it));
      endcase
    end

    for (int l = 0; l < 32; l += 7) classic(0, l, 16'h0000, '0, $sformatf("final%0d", l));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
